// File: rtl/e_fsm_pkg.sv
// -----------------------------------------------------------------------------
// e_fsm_pkg
// Shared definitions for the four-floor elevator controller:
//   - state_t      : 4-bit motion state {busy, dir, floor/lower floor}
//   - _1U.._4D     : hall-call codes {dir, floor}, floor 00 means floor 4
//   - UP/DOWN/STAY : motion codes driven on dout
//   - floor_dec    : 2-bit floor field to floor number 1..4
//   - is_valid_call: true for the six legal hall-call codes
// -----------------------------------------------------------------------------
package e_fsm_pkg;

    typedef enum logic [3:0] {
        S1  = 4'b0001,
        S2  = 4'b0010,
        S3  = 4'b0011,
        S4  = 4'b0100,
        S12 = 4'b1001,
        S21 = 4'b1101,
        S23 = 4'b1010,
        S32 = 4'b1110,
        S34 = 4'b1011,
        S43 = 4'b1111
    } state_t;

    localparam logic [2:0] _1U = 3'b001;
    localparam logic [2:0] _2U = 3'b010;
    localparam logic [2:0] _3U = 3'b011;
    localparam logic [2:0] _2D = 3'b110;
    localparam logic [2:0] _3D = 3'b111;
    localparam logic [2:0] _4D = 3'b100;

    localparam logic [1:0] UP   = 2'b00;
    localparam logic [1:0] DOWN = 2'b01;
    localparam logic [1:0] STAY = 2'b10;

    // Floor field 00 encodes the top floor.
    function automatic logic [2:0] floor_dec(input logic [1:0] f);
        return (f == 2'b00) ? 3'd4 : {1'b0, f};
    endfunction

    function automatic logic is_valid_call(input logic [2:0] c);
        logic ok;
        case (c)
            _1U, _2U, _3U, _2D, _3D, _4D: ok = 1'b1;
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/e_fsm_req_queue.sv
// -----------------------------------------------------------------------------
// e_fsm_req_queue
// Hall-call capture and 2-entry request FIFO.
// A call is enqueued when din holds a valid code that differs from the value
// seen on the previous cycle. When the FIFO is full new calls are dropped.
// Optional macro E_FSM_DEDUP_EN: a call equal to an entry already queued is
// dropped; otherwise duplicates are queued and each is serviced separately.
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   din[2:0] in   level-held hall-call code
//   done     in   pops the head entry on this clock edge
//   head[2:0]out  oldest queued call
//   q_empty  out  no call queued
// -----------------------------------------------------------------------------
module e_fsm_req_queue
    import e_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] din,
    input  logic       done,
    output logic [2:0] head,
    output logic       q_empty
);

    logic [2:0]      last_din_q, last_din_d;
    logic [1:0][2:0] mem_q, mem_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            is_new, dup, enq, pop;

    always_comb begin
        last_din_d = din;
        is_new     = is_valid_call(din) && (din != last_din_q);
        dup        = 1'b0;
`ifdef E_FSM_DEDUP_EN
        dup = ((cnt_q != 2'd0) && (din == mem_q[0])) ||
              ((cnt_q == 2'd2) && (din == mem_q[1]));
`endif
        enq   = is_new && !dup && (cnt_q != 2'd2);
        pop   = done && (cnt_q != 2'd0);
        mem_d = mem_q;
        cnt_d = cnt_q;
        // Pop first so a simultaneous enqueue lands in the freed slot.
        if (pop) begin
            mem_d[0] = mem_q[1];
            cnt_d    = cnt_q - 2'd1;
        end
        if (enq) begin
            mem_d[cnt_d[0]] = din;
            cnt_d           = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_din_q <= 3'b000;
            cnt_q      <= 2'd0;
        end else begin
            last_din_q <= last_din_d;
            cnt_q      <= cnt_d;
        end
    end

    // Entry storage needs no reset: the count marks which slots are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head    = mem_q[0];
    assign q_empty = (cnt_q == 2'd0);

endmodule

// File: rtl/e_fsm.sv
// -----------------------------------------------------------------------------
// e_fsm
// Four-floor elevator motion controller. Queues hall calls (e_fsm_req_queue)
// and services them one at a time, moving floor by floor; each between-floor
// state lasts TRAVEL_CYCLES cycles.
// Optional macro E_FSM_DEDUP_EN (in e_fsm_req_queue): drop duplicate calls.
// Parameters:
//   TRAVEL_CYCLES  cycles per between-floor state (>= 1), default 4
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   din[2:0]   in   hall call {dir, floor}, level-held
//   dout[1:0]  out  motion: 00 UP, 01 DOWN, 10 STAY
// -----------------------------------------------------------------------------
module e_fsm
    import e_fsm_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] din,
    output logic [1:0] dout
);

    localparam int CNT_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRAVEL_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [2:0]       head;
    logic             q_empty;
    logic [2:0]       cur_floor, tgt_floor, next_floor, seg_lo;
    logic             legal;
    logic             unused_head_dir;

    e_fsm_req_queue u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .done    (done_q),
        .head    (head),
        .q_empty (q_empty)
    );

    // Call direction is kept in the queue but motion depends only on floor.
    assign unused_head_dir = head[2];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        tgt_floor  = floor_dec(head[1:0]);
        cur_floor  = state_q[2:0];
        next_floor = 3'd0;
        seg_lo     = 3'd0;
        legal      = state_q inside {S1, S2, S3, S4, S12, S21, S23, S32, S34, S43};

        if (!legal) begin
            state_d = S1;
            cnt_d   = '0;
        end else if (!state_q[3]) begin
            // Idle: idle encodings carry the floor number directly in [2:0].
            cnt_d = '0;
            if (!q_empty && !done_q) begin
                if (tgt_floor > cur_floor) begin
                    state_d = state_t'({2'b10, cur_floor[1:0]});
                end else if (tgt_floor < cur_floor) begin
                    seg_lo  = cur_floor - 3'd1;
                    state_d = state_t'({2'b11, seg_lo[1:0]});
                end else begin
                    done_d = 1'b1;
                end
            end
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            // End of a segment: arrive at the far floor of the segment.
            cnt_d      = '0;
            next_floor = state_q[2] ? {1'b0, state_q[1:0]}
                                    : ({1'b0, state_q[1:0]} + 3'd1);
            if ((next_floor == tgt_floor) || (next_floor == 3'd1) || (next_floor == 3'd4)) begin
                state_d = state_t'({1'b0, next_floor});
                done_d  = (next_floor == tgt_floor);
            end else if (state_q[2]) begin
                seg_lo  = next_floor - 3'd1;
                state_d = state_t'({2'b11, seg_lo[1:0]});
            end else begin
                state_d = state_t'({2'b10, next_floor[1:0]});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S1;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        dout = STAY;
        if (state_q[3]) begin
            dout = state_q[2] ? DOWN : UP;
        end
    end

endmodule

// File: tb/tb_e_fsm.sv
module tb_e_fsm;
    import e_fsm_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] din   = 3'b000;
    logic [1:0] dout;

    int n_checks = 0;
    int n_pass   = 0;

    e_fsm #(.TRAVEL_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [2:0] din;
        logic [1:0] dout;
        logic [3:0] st;
        logic       qe;
        logic       done;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int n, input logic r, input logic [2:0] d, input logic [1:0] o,
                       input logic [3:0] s, input logic qe, input logic dn);
        vec_t v;
        v.rst_n = r; v.din = d; v.dout = o; v.st = s; v.qe = qe; v.done = dn;
        for (int i = 0; i < n; i++) vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic check_all(input string name, input logic [1:0] o, input logic [3:0] s,
                             input logic qe, input logic dn);
        check({name, ".dout"},  dout,          o);
        check({name, ".state"}, dut.state_q,   s);
        check({name, ".qe"},    dut.q_empty,   qe);
        check({name, ".done"},  dut.done_q,    dn);
    endtask

    // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
    task automatic tick(input logic r, input logic [2:0] d);
        @(negedge clk);
        rst_n = r;
        din   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string name);
        int k = 0;
        while (dut.state_q !== s && k < budget) begin
            tick(rst_n, din);
            k++;
        end
        check(name, dut.state_q, s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_qe_after_pop;
        logic exp_done_dup;
`ifdef E_FSM_DEDUP_EN
        exp_qe_after_pop = 1'b1;
        exp_done_dup     = 1'b0;
`else
        exp_qe_after_pop = 1'b0;
        exp_done_dup     = 1'b1;
`endif

        // Reset, 1->3 trip, 3->2 trip, same-floor call at 2, reset, same-floor call at 1.
        add(2, 0, 3'b000, STAY, S1,  1, 0);
        add(1, 1, 3'b000, STAY, S1,  1, 0);
        add(1, 1, _3U,    STAY, S1,  0, 0);
        add(4, 1, _3U,    UP,   S12, 0, 0);
        add(4, 1, _3U,    UP,   S23, 0, 0);
        add(1, 1, _3U,    STAY, S3,  0, 1);
        add(1, 1, _3U,    STAY, S3,  1, 0);
        add(1, 1, _2D,    STAY, S3,  0, 0);
        add(4, 1, _2D,    DOWN, S32, 0, 0);
        add(1, 1, _2D,    STAY, S2,  0, 1);
        add(1, 1, _2D,    STAY, S2,  1, 0);
        add(1, 1, _2U,    STAY, S2,  0, 0);
        add(1, 1, _2U,    STAY, S2,  0, 1);
        add(1, 1, _2U,    STAY, S2,  1, 0);
        add(1, 0, 3'b000, STAY, S1,  1, 0);
        add(1, 1, _1U,    STAY, S1,  0, 0);
        add(1, 1, _1U,    STAY, S1,  0, 1);
        add(1, 1, _1U,    STAY, S1,  1, 0);

        foreach (vq[i]) begin
            tick(vq[i].rst_n, vq[i].din);
            check_all($sformatf("vec%0d", i), vq[i].dout, vq[i].st, vq[i].qe, vq[i].done);
        end

        // Queue full during a 1->4 trip: 010 fills the second slot, 111 and 110 drop.
        tick(0, 3'b000);
        tick(0, 3'b000);
        tick(1, _4D);
        check("full.enq4D.qe", dut.q_empty, 1'b0);
        tick(1, _4D);
        check_all("full.start", UP, S12, 0, 0);
        tick(1, _2U);
        tick(1, _3D);
        tick(1, _2D);
        wait_state(S4, 20, "full.arrive4");
        check("full.arrive4.done", dut.done_q, 1'b1);
        check("full.arrive4.dout", dout, STAY);
        tick(1, _2D);
        check("full.pop4.qe", dut.q_empty, 1'b0);
        check("full.pop4.done", dut.done_q, 1'b0);
        wait_state(S43, 4, "full.leave4");
        check("full.leave4.dout", dout, DOWN);
        wait_state(S2, 20, "full.arrive2");
        check("full.arrive2.done", dut.done_q, 1'b1);
        tick(1, _2D);
        check("full.drop.qe", dut.q_empty, 1'b1);
        tick(1, _2D);
        tick(1, _2D);
        check_all("full.settled", STAY, S2, 1, 0);

        // Duplicate 4D call with a 000 gap.
        tick(0, 3'b000);
        tick(0, 3'b000);
        tick(1, _4D);
        tick(1, 3'b000);
        tick(1, _4D);
        wait_state(S4, 20, "dup.arrive4");
        check("dup.arrive4.done", dut.done_q, 1'b1);
        tick(1, _4D);
        check("dup.afterpop.qe", dut.q_empty, exp_qe_after_pop);
        tick(1, _4D);
        check("dup.second.done", dut.done_q, exp_done_dup);
        tick(1, _4D);
        check_all("dup.final", STAY, S4, 1, 0);

        // Reset in the middle of a trip.
        tick(0, 3'b000);
        tick(0, 3'b000);
        tick(1, _3U);
        wait_state(S23, 12, "rst.reachS23");
        tick(0, 3'b000);
        check_all("rst.mid", STAY, S1, 1, 0);
        tick(1, 3'b000);
        check_all("rst.after", STAY, S1, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
